// File: rtl/regfile_write_arbiter_pkg.sv
// Shared register-file definitions: default widths, grant encodings and the
// round-robin pick rule used by the write arbiter.
package regfile_write_arbiter_pkg;

  localparam int unsigned RF_DW = 32;
  localparam int unsigned RF_AW = 5;

  typedef enum logic {
    GRANT_A = 1'b0,
    GRANT_B = 1'b1
  } grant_e;

  // A lone requester always wins; on contention the one not granted last wins.
  function automatic grant_e rr_pick(input logic a_valid, input logic b_valid,
                                     input grant_e last);
    if (a_valid && b_valid) begin
      return (last == GRANT_A) ? GRANT_B : GRANT_A;
    end else if (b_valid) begin
      return GRANT_B;
    end else begin
      return GRANT_A;
    end
  endfunction

endpackage

// File: rtl/regfile_write_arbiter_rr_arbiter2.sv
// Two-way round-robin grant with its last-grant flop. Grants are combinational
// and forced low while reset is asserted.
module rr_arbiter2
  import regfile_write_arbiter_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic a_valid,
  input  logic b_valid,
  output logic a_grant,
  output logic b_grant,
  output logic last_grant
);

  grant_e last_q;
  grant_e last_d;
  grant_e pick;

  always_comb begin
    pick    = rr_pick(a_valid, b_valid, last_q);
    a_grant = 1'b0;
    b_grant = 1'b0;
    last_d  = last_q;
    if (rst_n && (a_valid || b_valid)) begin
      a_grant = (pick == GRANT_A);
      b_grant = (pick == GRANT_B);
      last_d  = pick;
    end
  end

  // Reset to B so that A wins the first contention.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_q <= GRANT_B;
    end else begin
      last_q <= last_d;
    end
  end

  assign last_grant = logic'(last_q);

endmodule

// File: rtl/regfile_write_arbiter.sv
// Arbitrates two write-back requesters onto a single register-file write port
// with one cycle of latency; writes to register 0 are accepted but suppressed.
module regfile_write_arbiter
  import regfile_write_arbiter_pkg::*;
#(
  parameter int unsigned DW = RF_DW,
  parameter int unsigned AW = RF_AW
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          a_valid,
  input  logic [AW-1:0] a_reg,
  input  logic [DW-1:0] a_data,
  output logic          a_ready,
  input  logic          b_valid,
  input  logic [AW-1:0] b_reg,
  input  logic [DW-1:0] b_data,
  output logic          b_ready,
  output logic          reg_write,
  output logic [AW-1:0] wreg,
  output logic [DW-1:0] wdata,
  output logic          last_grant
);

  logic          a_grant;
  logic          b_grant;
  logic          xfer;
  logic [AW-1:0] sel_reg;
  logic [DW-1:0] sel_data;

  logic          reg_write_q, reg_write_d;
  logic [AW-1:0] wreg_q, wreg_d;
  logic [DW-1:0] wdata_q, wdata_d;

  rr_arbiter2 u_rr (
    .clk       (clk),
    .rst_n     (rst_n),
    .a_valid   (a_valid),
    .b_valid   (b_valid),
    .a_grant   (a_grant),
    .b_grant   (b_grant),
    .last_grant(last_grant)
  );

  assign a_ready = a_grant;
  assign b_ready = b_grant;

  // Idle cycles drop the strobe but keep the last address/data on the port.
  always_comb begin
    xfer        = a_grant | b_grant;
    sel_reg     = b_grant ? b_reg : a_reg;
    sel_data    = b_grant ? b_data : a_data;
    reg_write_d = 1'b0;
    wreg_d      = wreg_q;
    wdata_d     = wdata_q;
    if (xfer) begin
      reg_write_d = (sel_reg != '0);
      wreg_d      = sel_reg;
      wdata_d     = sel_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      reg_write_q <= 1'b0;
      wreg_q      <= '0;
      wdata_q     <= '0;
    end else begin
      reg_write_q <= reg_write_d;
      wreg_q      <= wreg_d;
      wdata_q     <= wdata_d;
    end
  end

  assign reg_write = reg_write_q;
  assign wreg      = wreg_q;
  assign wdata     = wdata_q;

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Scoreboard bench for regfile_write_arbiter: stimulus queues hand-computed
// grants, a negedge monitor checks handshakes and the delayed write port.
module tb_regfile_write_arbiter;

  logic        clk;
  logic        rst_n;
  logic        a_valid;
  logic [4:0]  a_reg;
  logic [31:0] a_data;
  logic        a_ready;
  logic        b_valid;
  logic [4:0]  b_reg;
  logic [31:0] b_data;
  logic        b_ready;
  logic        reg_write;
  logic [4:0]  wreg;
  logic [31:0] wdata;
  logic        last_grant;

  typedef struct {
    logic        g;
    logic [4:0]  r;
    logic [31:0] d;
  } exp_t;

  exp_t expQ[$];

  int assertCount;
  int failCount;

  logic        expRw;
  logic [4:0]  expWreg;
  logic [31:0] expWdata;
  logic        expLg;

  regfile_write_arbiter #(.DW(32), .AW(5)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .a_valid   (a_valid),
    .a_reg     (a_reg),
    .a_data    (a_data),
    .a_ready   (a_ready),
    .b_valid   (b_valid),
    .b_reg     (b_reg),
    .b_data    (b_data),
    .b_ready   (b_ready),
    .reg_write (reg_write),
    .wreg      (wreg),
    .wdata     (wdata),
    .last_grant(last_grant)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic checkOutput(input string name, input logic [63:0] act,
                             input logic [63:0] exp);
    assertCount++;
    if (act !== exp) begin
      failCount++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Drive one cycle of inputs, then advance to just after the next rising edge.
  task automatic applyStimulus(input logic av, input logic [4:0] ar, input logic [31:0] ad,
                               input logic bv, input logic [4:0] br, input logic [31:0] bd);
    a_valid = av;
    a_reg   = ar;
    a_data  = ad;
    b_valid = bv;
    b_reg   = br;
    b_data  = bd;
    @(posedge clk);
    #1;
  endtask

  task automatic pushExp(input logic g, input logic [4:0] r, input logic [31:0] d);
    exp_t e;
    e.g = g;
    e.r = r;
    e.d = d;
    expQ.push_back(e);
  endtask

  // Monitor: checks the write port against the previous cycle's transfer and
  // matches each observed handshake against the next queued expectation.
  initial begin
    exp_t item;
    expRw    = 1'b0;
    expWreg  = '0;
    expWdata = '0;
    expLg    = 1'b1;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        checkOutput("rst_reg_write", reg_write, 0);
        checkOutput("rst_wreg", wreg, 0);
        checkOutput("rst_wdata", wdata, 0);
        checkOutput("rst_last_grant", last_grant, 1);
        checkOutput("rst_a_ready", a_ready, 0);
        checkOutput("rst_b_ready", b_ready, 0);
        expRw    = 1'b0;
        expWreg  = '0;
        expWdata = '0;
        expLg    = 1'b1;
      end else begin
        checkOutput("reg_write", reg_write, expRw);
        checkOutput("wreg", wreg, expWreg);
        checkOutput("wdata", wdata, expWdata);
        checkOutput("last_grant", last_grant, expLg);
        expRw = 1'b0;
        if ((a_valid && a_ready) || (b_valid && b_ready)) begin
          if (expQ.size() == 0) begin
            assertCount++;
            failCount++;
            $display("[TB] FAIL unexpected_transfer: a_ready=%0b b_ready=%0b, none expected at %0t",
                     a_ready, b_ready, $time);
          end else begin
            item = expQ.pop_front();
            checkOutput("grant_a", a_ready, {63'd0, ~item.g});
            checkOutput("grant_b", b_ready, {63'd0, item.g});
            expRw    = (item.r != 5'd0);
            expWreg  = item.r;
            expWdata = item.d;
            expLg    = item.g;
          end
        end else begin
          checkOutput("missed_grant", {a_valid, b_valid}, 0);
          checkOutput("stray_ready", {a_ready, b_ready}, 0);
        end
      end
    end
  end

  initial begin
    assertCount = 0;
    failCount   = 0;
    rst_n       = 1'b0;

    // Readies must stay low in reset even with both requesters valid.
    for (int i = 0; i < 3; i++) applyStimulus(1, 5'd4, 32'h1111_1111, 1, 5'd6, 32'h2222_2222);

    // Single A write right after reset.
    rst_n = 1'b1;
    pushExp(1'b0, 5'd3, 32'h8C12_3456);
    applyStimulus(1, 5'd3, 32'h8C12_3456, 0, 5'd0, 32'h0);
    applyStimulus(0, 5'd0, 32'h0, 0, 5'd0, 32'h0);

    // Contention immediately after a fresh reset: A first, then B.
    rst_n = 1'b0;
    applyStimulus(0, 5'd0, 32'h0, 0, 5'd0, 32'h0);
    applyStimulus(0, 5'd0, 32'h0, 0, 5'd0, 32'h0);
    rst_n = 1'b1;
    pushExp(1'b0, 5'd1, 32'h1065_4321);
    applyStimulus(1, 5'd1, 32'h1065_4321, 1, 5'd2, 32'h0010_0022);
    pushExp(1'b1, 5'd2, 32'h0010_0022);
    applyStimulus(1, 5'd1, 32'h1065_4321, 1, 5'd2, 32'h0010_0022);
    applyStimulus(0, 5'd0, 32'h0, 0, 5'd0, 32'h0);

    // Eight cycles of continuous contention alternate A, B, A, B ...
    for (int i = 0; i < 8; i++) begin
      if (i % 2 == 0) pushExp(1'b0, 5'd7, 32'h0000_7777);
      else            pushExp(1'b1, 5'd9, 32'h9999_0000);
      applyStimulus(1, 5'd7, 32'h0000_7777, 1, 5'd9, 32'h9999_0000);
    end

    // B to register 0: accepted, no strobe, address/data still update.
    pushExp(1'b1, 5'd0, 32'hAD65_4321);
    applyStimulus(0, 5'd0, 32'h0, 1, 5'd0, 32'hAD65_4321);

    // Three idle cycles: port holds reg 0 / 0xAD654321, last_grant stays B.
    for (int i = 0; i < 3; i++) applyStimulus(0, 5'd0, 32'h0, 0, 5'd0, 32'h0);

    // Contention won by A, then B drops out; nothing of B is retained.
    pushExp(1'b0, 5'd10, 32'hAAAA_000A);
    applyStimulus(1, 5'd10, 32'hAAAA_000A, 1, 5'd11, 32'hBBBB_000B);
    pushExp(1'b0, 5'd12, 32'hCCCC_000C);
    applyStimulus(1, 5'd12, 32'hCCCC_000C, 0, 5'd11, 32'hBBBB_000B);

    // A write to reg 5 is killed by reset before it reaches the port.
    pushExp(1'b0, 5'd5, 32'h0000_0055);
    applyStimulus(1, 5'd5, 32'h0000_0055, 0, 5'd0, 32'h0);
    rst_n = 1'b0;
    applyStimulus(0, 5'd0, 32'h0, 0, 5'd0, 32'h0);
    rst_n = 1'b1;
    applyStimulus(0, 5'd0, 32'h0, 0, 5'd0, 32'h0);
    applyStimulus(0, 5'd0, 32'h0, 0, 5'd0, 32'h0);
    applyStimulus(0, 5'd0, 32'h0, 0, 5'd0, 32'h0);

    checkOutput("queue_drained", expQ.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule

// File: doc/regfile_write_arbiter.md
REGFILE_WRITE_ARBITER -- requirements
Module: regfile_write_arbiter

Interface
REQ-001 Parameter DW, default 32: data width of the register file write data.
REQ-002 Parameter AW, default 5: register address width (32 registers).
REQ-003 Port clk  input  1: single clock; all state updates on rising edge.
REQ-004 Port rst_n  input  1: reset, asynchronous and active-low.
REQ-005 Port a_valid  input  1: requester A (pipeline write-back) has a write pending.
REQ-006 Port a_reg  input  AW: requester A destination register.
REQ-007 Port a_data  input  DW: requester A write data.
REQ-008 Port a_ready  output  1: requester A write accepted this cycle.
REQ-009 Port b_valid  input  1: requester B (multicycle unit) has a write pending.
REQ-010 Port b_reg  input  AW: requester B destination register.
REQ-011 Port b_data  input  DW: requester B write data.
REQ-012 Port b_ready  output  1: requester B write accepted this cycle.
REQ-013 Port reg_write  output  1: write strobe to the register file write port.
REQ-014 Port wreg  output  AW: write register address to the register file.
REQ-015 Port wdata  output  DW: write data to the register file.
REQ-016 Port last_grant  output  1: 0 = A granted most recently, 1 = B.

Function
REQ-017 A transfer occurs on requester X when x_valid and x_ready are both high at a rising clk edge.
REQ-018 a_ready and b_ready are combinational from the valid inputs and the round-robin state; at most one is high in any cycle.
REQ-019 If only one requester is valid, that requester is granted in the same cycle.
REQ-020 If both requesters are valid, the requester not equal to last_grant is granted (round-robin).
REQ-021 If neither requester is valid, both readies are low and last_grant holds.
REQ-022 last_grant updates on every transfer to the requester just granted.
REQ-023 reg_write, wreg and wdata are registered: a transfer at edge N drives the write-port outputs during cycle N+1 (latency 1).
REQ-024 reg_write is high in cycle N+1 only if a transfer occurred at edge N and the transferred register address is nonzero.
REQ-025 A transfer to register 0 is accepted (ready asserted) but produces reg_write = 0; wreg and wdata still update.
REQ-026 With no transfer at edge N, reg_write is 0 in cycle N+1 and wreg/wdata hold their previous values.
REQ-027 Back-to-back transfers are sustained at one per cycle; with both requesters continuously valid, grants alternate A, B, A, B.
REQ-028 A requester that drops valid while not granted loses nothing; no request is stored internally.
REQ-029 Requesters hold reg/data stable while valid and not ready; the arbiter samples reg/data only on the transfer edge.

Reset
REQ-030 While rst_n is low: reg_write = 0, wreg = 0, wdata = 0, last_grant = 1, so A wins the first contention after reset.
REQ-031 a_ready and b_ready are forced low while rst_n is low, regardless of the valid inputs.
REQ-032 Reset asserted mid-operation clears a pending registered write immediately; that write is never issued.
REQ-033 The first transfer can occur at the first rising edge after rst_n deasserts.

Structure
REQ-034 AW, DW defaults and the grant encodings (GRANT_A = 0, GRANT_B = 1) are defined in the shared regfile package used by the register file and this arbiter.
REQ-035 The block is flat except for one sub-module, rr_arbiter2: a 2-way round-robin grant function with its last-grant flop.

Verification
REQ-036 Reset, then a_valid=1, a_reg=3, a_data=0x8C123456 for one cycle -> a_ready=1 that cycle; the next cycle has reg_write=1, wreg=3, wdata=0x8C123456.
REQ-037 Right after reset, both valid: A reg 1 data 0x10654321, B reg 2 data 0x00100022, held -> cycle 1 grants A, cycle 2 grants B; write port shows reg 1 then reg 2 on consecutive cycles.
REQ-038 Both valid continuously for 8 cycles -> grants strictly alternate, 4 to each; last_grant toggles every cycle.
REQ-039 b_valid=1, b_reg=0, b_data=0xAD654321 -> b_ready=1; the next cycle has reg_write=0, wreg=0, wdata=0xAD654321.
REQ-040 Transfer A reg 5 at edge N; rst_n pulled low before edge N+1 -> reg_write=0 immediately; after release, outputs are 0 and last_grant=1.
REQ-041 Neither requester valid for 3 cycles after traffic -> reg_write=0, wreg/wdata hold their last values, last_grant unchanged.
